// File: rtl/ram_dual_port_be.sv
// True dual-port RAM with per-lane byte enables, selectable read-during-write,
// optional output register, same-address collision flag and post-reset clear sweep.
module ram_dual_port_be #(
    parameter int                        DATA_WIDTH     = 24,
    parameter int                        LANE_WIDTH     = 8,
    parameter int                        ADDRESS_WIDTH  = 10,
    parameter int                        RDW_MODE       = 0,
    parameter int                        OUT_REG        = 0,
    parameter int                        CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE     = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    output logic                                 init_busy_o,

    input  logic                                 enA_i,
    input  logic                                 weA_i,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]     beA_i,
    input  logic [ADDRESS_WIDTH-1:0]             addrA_i,
    input  logic [DATA_WIDTH-1:0]                dataA_i,
    output logic [DATA_WIDTH-1:0]                qA_o,
    output logic                                 validA_o,

    input  logic                                 enB_i,
    input  logic                                 weB_i,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]     beB_i,
    input  logic [ADDRESS_WIDTH-1:0]             addrB_i,
    input  logic [DATA_WIDTH-1:0]                dataB_i,
    output logic [DATA_WIDTH-1:0]                qB_o,
    output logic                                 validB_o,

    output logic                                 collision_o
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clrAddr_q, clrAddr_d;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                     issueA, issueB, wrA, wrB, collide;
    logic [DATA_WIDTH-1:0]    oldA, oldB, retA, retB;

    logic [DATA_WIDTH-1:0]    q1A_q, q1B_q;
    logic                     v1A_q, v1B_q, col1_q;

    function automatic logic [DATA_WIDTH-1:0] mergeLanes(
        input logic [DATA_WIDTH-1:0] oldWord,
        input logic [DATA_WIDTH-1:0] newWord,
        input logic [LANES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] res;
        res = oldWord;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) res[i*LANE_WIDTH +: LANE_WIDTH] = newWord[i*LANE_WIDTH +: LANE_WIDTH];
        end
        return res;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RESET_STATE;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        if (state_q == ST_CLEAR) begin
            clrAddr_d = clrAddr_q + ADDRESS_WIDTH'(1);
            if (&clrAddr_q) state_d = ST_RUN;
        end
    end

    assign init_busy_o = (state_q == ST_CLEAR);

    // Ports are masked entirely while the sweep owns the array.
    assign issueA  = enA_i && (state_q == ST_RUN);
    assign issueB  = enB_i && (state_q == ST_RUN);
    assign wrA     = issueA && weA_i && (|beA_i);
    assign wrB     = issueB && weB_i && (|beB_i);
    assign collide = issueA && issueB && (addrA_i == addrB_i) && (wrA || wrB);

    assign oldA = mem[addrA_i];
    assign oldB = mem[addrB_i];
    assign retA = (RDW_MODE == 0 && wrA) ? mergeLanes(oldA, dataA_i, beA_i) : oldA;
    assign retB = (RDW_MODE == 0 && wrB) ? mergeLanes(oldB, dataB_i, beB_i) : oldB;

    // Port A is written last so its enabled lanes win a same-address write/write.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem[clrAddr_q] <= INIT_VALUE;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wrB && beB_i[i])
                    mem[addrB_i][i*LANE_WIDTH +: LANE_WIDTH] <= dataB_i[i*LANE_WIDTH +: LANE_WIDTH];
                if (wrA && beA_i[i])
                    mem[addrA_i][i*LANE_WIDTH +: LANE_WIDTH] <= dataA_i[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q1A_q  <= '0;
            q1B_q  <= '0;
            v1A_q  <= 1'b0;
            v1B_q  <= 1'b0;
            col1_q <= 1'b0;
        end else begin
            v1A_q  <= issueA;
            v1B_q  <= issueB;
            col1_q <= collide;
            if (issueA) q1A_q <= retA;
            if (issueB) q1B_q <= retB;
        end
    end

    generate
        if (OUT_REG != 0) begin : gOutReg
            logic [DATA_WIDTH-1:0] q2A_q, q2B_q;
            logic                  v2A_q, v2B_q, col2_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    q2A_q  <= '0;
                    q2B_q  <= '0;
                    v2A_q  <= 1'b0;
                    v2B_q  <= 1'b0;
                    col2_q <= 1'b0;
                end else begin
                    v2A_q  <= v1A_q;
                    v2B_q  <= v1B_q;
                    col2_q <= col1_q;
                    if (v1A_q) q2A_q <= q1A_q;
                    if (v1B_q) q2B_q <= q1B_q;
                end
            end

            assign qA_o        = q2A_q;
            assign qB_o        = q2B_q;
            assign validA_o    = v2A_q;
            assign validB_o    = v2B_q;
            assign collision_o = col2_q;
        end else begin : gNoOutReg
            assign qA_o        = q1A_q;
            assign qB_o        = q1B_q;
            assign validA_o    = v1A_q;
            assign validB_o    = v1B_q;
            assign collision_o = col1_q;
        end
    endgenerate

endmodule

// File: doc/ram_dual_port_be.md
Name: ram_dual_port_be

Overview:
- True dual-port block RAM for line buffers and coefficient stores.
- Adds per-lane byte enables, a selectable read-during-write mode, an optional output register stage, and per-port read-valid tracking.
- Adds same-address collision arbitration with a flag output, and a post-reset clear state machine that fills the array with a known value.
- Drop-in successor for existing two-port line-buffer storage in the scaler datapath.

Parameters:
- DATA_WIDTH, 24, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per byte-enable lane; LANES = DATA_WIDTH/LANE_WIDTH.
- ADDRESS_WIDTH, 10, address bits; DEPTH = 2**ADDRESS_WIDTH.
- RDW_MODE, 0, own-port read-during-write: 0 = write-first (q returns new merged word), 1 = read-first (q returns old word).
- OUT_REG, 0, 1 adds one output pipeline register; read latency = 1 + OUT_REG.
- CLEAR_ON_RESET, 1, 1 enables the post-reset clear sweep.
- INIT_VALUE, 0, DATA_WIDTH-bit word written to every address by the sweep.

Ports:
- clk, input, 1, single clock for both ports.
- rst_n, input, 1, asynchronous active-low reset.
- init_busy, output, 1, high while the clear sweep runs; port requests are ignored while high.
- enA, input, 1, port A access request.
- weA, input, 1, port A write (qualified by enA).
- beA, input, LANES, port A lane write enables.
- addrA, input, ADDRESS_WIDTH, port A address.
- dataA, input, DATA_WIDTH, port A write data.
- qA, output, DATA_WIDTH, port A read data.
- validA, output, 1, qA holds data for an access issued 1+OUT_REG cycles earlier.
- enB, weB, beB, addrB, dataB, qB, validB: port B, identical to port A.
- collision, output, 1, one-cycle pulse aligned with validA for a same-address write/write or read/write collision.

Behaviour:
- Reset (rst_n low, asynchronous):
  - qA, qB, validA, validB and collision are cleared to 0, including the OUT_REG stage.
  - The FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise to RUN.
  - init_busy = CLEAR_ON_RESET while reset is held.
  - Array contents are not reset.
- FSM states:
  - CLEAR: an internal counter writes INIT_VALUE to address 0,1,…,DEPTH-1, one address per clk. The transition to RUN happens on the cycle after address DEPTH-1 is written, so init_busy is high for exactly DEPTH cycles after reset release.
  - RUN: normal operation; remains in RUN until the next reset.
  - Reset asserted mid-CLEAR: the sweep restarts from address 0 after release.
- CLEAR masking: enA and enB are forced to 0; validA and validB stay 0; no writes from either port.
- Access: an access is issued when enX=1 and the FSM is in RUN.
- Write: with weX=1, only lanes with beX[i]=1 are updated. beX=0 with weX=1 is treated as a read.
- Read data: qX updates 1+OUT_REG cycles after issue; validX follows enX with the same latency, for reads and writes alike.
- qX is held when no access is issued; validX is 0 in that case.
- Write-access return data:
  - RDW_MODE=0: qX = old word with the written lanes replaced by the new data.
  - RDW_MODE=1: qX = old word.
- Write/write collision (both ports write the same address in the same cycle):
  - Lane-wise merge: lanes enabled in beA take dataA; lanes enabled only in beB take dataB; other lanes are unchanged.
  - collision pulses.
- Read/write collision (one port reads an address the other port writes in the same cycle):
  - The reader gets the old word.
  - collision pulses.
- Same-address read/read: no collision; both ports see the same data.
- Address wrap: none; addresses are exact, and DEPTH-1 is a valid final address.
- Port A and port B are otherwise fully independent; a full-throughput access is possible every cycle on each port.

Test Plan:
- Clear sweep: ADDRESS_WIDTH=4, INIT_VALUE=24'hA5A5A5, release rst_n → init_busy high for exactly 16 cycles; then reads of addresses 0..15 return 24'hA5A5A5 with validA asserted 1 cycle later (OUT_REG=0).
- Byte enables: address 3 holds 24'h112233; port A writes 24'hAABBCC with beA=3'b010 → a later read of address 3 returns 24'h11BB33.
- RDW modes: RDW_MODE=0 vs 1; address 5 holds 24'h000001; a write of 24'h000002 with beA=3'b111 → qA = 24'h000002 vs 24'h000001, each with validA.
- Write collision: both ports write address 7, beA=3'b001 with dataA=24'h0000AA, beB=3'b111 with dataB=24'h123456 → address 7 reads 24'h1234AA; collision pulses once.
- Read/write collision and latency: OUT_REG=1; port B reads address 9 (holding 24'h000010) while port A writes 24'h000020 there → qB = 24'h000010 and validB both 2 cycles later; collision asserted aligned with validA.
- Reset mid-sweep: assert rst_n low at sweep address 6 → qX=0, validX=0; after release, init_busy is high for the full DEPTH cycles again, and every address holds INIT_VALUE.
